// File: rtl/parking_lot_counter_if.sv
// Sensor and status bundle between the beam synchronisers and the occupancy counter.
// The master side drives the beams; the slave side is the counter itself.
interface parking_lot_counter_if #(
   parameter int LANES = 2,
   parameter int CNT_W = 4
);
   logic [LANES-1:0] sensor_a;
   logic [LANES-1:0] sensor_b;
   logic [LANES-1:0] enter_pulse;
   logic [LANES-1:0] exit_pulse;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;
   logic             overflow;
   logic             underflow;

   modport master (
      output sensor_a, sensor_b,
      input  enter_pulse, exit_pulse, count, full, empty, overflow, underflow
   );

   modport slave (
      input  sensor_a, sensor_b,
      output enter_pulse, exit_pulse, count, full, empty, overflow, underflow
   );
endinterface

// File: rtl/parking_lot_counter.sv
// Multi-lane parking-lot occupancy counter: per-lane direction FSMs feed one
// saturating occupancy count with full/empty status and clamp error pulses.
module parking_lot_counter #(
   parameter int LANES    = 2,
   parameter int CAPACITY = 15,
   parameter int CNT_W    = $clog2(CAPACITY + 1)
) (
   input logic                   clk,
   input logic                   rst,
   parking_lot_counter_if.slave  bus
);

   localparam int EW    = $clog2(LANES + 1);
   localparam int SUM_W = CNT_W + EW + 1;
   localparam logic signed [SUM_W-1:0] CAP_S = SUM_W'(CAPACITY);

   typedef enum logic [2:0] {
      IDLE,
      IN_A,
      IN_AB,
      IN_B,
      OUT_B,
      OUT_AB,
      OUT_A
   } laneState_e;

   logic [LANES-1:0] enterDone;
   logic [LANES-1:0] exitDone;

   logic [LANES-1:0] enterPulse_q;
   logic [LANES-1:0] exitPulse_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;

   logic [EW-1:0]           entCnt;
   logic [EW-1:0]           extCnt;
   logic signed [SUM_W-1:0] nextSum;

   for (genvar g = 0; g < LANES; g++) begin : gLane
      laneState_e state_q;
      logic [1:0] ab;

      assign ab = {bus.sensor_a[g], bus.sensor_b[g]};
      assign enterDone[g] = (state_q == IN_B)  && (ab == 2'b00);
      assign exitDone[g]  = (state_q == OUT_A) && (ab == 2'b00);

      // 11 from IDLE is ambiguous, so a lane only commits to a direction on a single beam.
      always_ff @(posedge clk) begin
         if (rst) begin
            state_q <= IDLE;
         end else begin
            case (state_q)
               IDLE:    if (ab == 2'b10) state_q <= IN_A;
                        else if (ab == 2'b01) state_q <= OUT_B;
               IN_A:    if (ab == 2'b11) state_q <= IN_AB;
                        else if (ab != 2'b10) state_q <= IDLE;
               IN_AB:   if (ab == 2'b01) state_q <= IN_B;
                        else if (ab == 2'b10) state_q <= IN_A;
                        else if (ab == 2'b00) state_q <= IDLE;
               IN_B:    if (ab == 2'b11) state_q <= IN_AB;
                        else if (ab != 2'b01) state_q <= IDLE;
               OUT_B:   if (ab == 2'b11) state_q <= OUT_AB;
                        else if (ab != 2'b01) state_q <= IDLE;
               OUT_AB:  if (ab == 2'b10) state_q <= OUT_A;
                        else if (ab == 2'b01) state_q <= OUT_B;
                        else if (ab == 2'b00) state_q <= IDLE;
               OUT_A:   if (ab == 2'b11) state_q <= OUT_AB;
                        else if (ab != 2'b10) state_q <= IDLE;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   // Entries and exits net out first, so only the combined result is clamped.
   always_comb begin
      entCnt = '0;
      extCnt = '0;
      for (int i = 0; i < LANES; i++) begin
         entCnt = entCnt + EW'(enterDone[i]);
         extCnt = extCnt + EW'(exitDone[i]);
      end
      nextSum     = SUM_W'(count_q) + SUM_W'(entCnt) - SUM_W'(extCnt);
      count_d     = nextSum[CNT_W-1:0];
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      if (nextSum[SUM_W-1]) begin
         count_d     = '0;
         underflow_d = 1'b1;
      end else if (nextSum > CAP_S) begin
         count_d    = CNT_W'(CAPACITY);
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         enterPulse_q <= '0;
         exitPulse_q  <= '0;
         count_q      <= '0;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
      end else begin
         enterPulse_q <= enterDone;
         exitPulse_q  <= exitDone;
         count_q      <= count_d;
         overflow_q   <= overflow_d;
         underflow_q  <= underflow_d;
      end
   end

   assign bus.enter_pulse = enterPulse_q;
   assign bus.exit_pulse  = exitPulse_q;
   assign bus.count       = count_q;
   assign bus.overflow    = overflow_q;
   assign bus.underflow   = underflow_q;
   assign bus.full        = (count_q == CNT_W'(CAPACITY));
   assign bus.empty       = (count_q == '0);

endmodule

// File: tb/tb_parking_lot_counter.sv
// Scoreboard bench for parking_lot_counter: a reference model of the lane
// sequences pushes expected outputs per driven cycle; they are popped after the edge.
module tb_parking_lot_counter;

   localparam int LANES    = 4;
   localparam int CAPACITY = 15;
   localparam int CNT_W    = 4;

   typedef enum int {M_IDLE, M_IN_A, M_IN_AB, M_IN_B, M_OUT_B, M_OUT_AB, M_OUT_A} mState_e;

   typedef struct {
      logic [LANES-1:0] ent;
      logic [LANES-1:0] ext;
      int               cnt;
      logic             ovf;
      logic             unf;
   } expect_t;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   int   cycleNo;
   int   mCount;
   mState_e mState [LANES];
   expect_t scoreboard [$];

   parking_lot_counter_if #(.LANES(LANES), .CNT_W(CNT_W)) bus ();

   parking_lot_counter #(
      .LANES(LANES),
      .CAPACITY(CAPACITY),
      .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycleNo, obs, exp);
      end
   endtask

   // Reference model step for one lane, written straight from the sequence table.
   task automatic modelLane(input int l, input logic [1:0] ab, output logic ent, output logic ext);
      mState_e s;
      s   = mState[l];
      ent = 1'b0;
      ext = 1'b0;
      case (s)
         M_IDLE:   s = (ab == 2'b10) ? M_IN_A : (ab == 2'b01) ? M_OUT_B : M_IDLE;
         M_IN_A:   s = (ab == 2'b10) ? M_IN_A : (ab == 2'b11) ? M_IN_AB : M_IDLE;
         M_IN_AB:  s = (ab == 2'b11) ? M_IN_AB : (ab == 2'b01) ? M_IN_B :
                       (ab == 2'b10) ? M_IN_A : M_IDLE;
         M_IN_B: begin
            if (ab == 2'b00) ent = 1'b1;
            s = (ab == 2'b01) ? M_IN_B : (ab == 2'b11) ? M_IN_AB : M_IDLE;
         end
         M_OUT_B:  s = (ab == 2'b01) ? M_OUT_B : (ab == 2'b11) ? M_OUT_AB : M_IDLE;
         M_OUT_AB: s = (ab == 2'b11) ? M_OUT_AB : (ab == 2'b10) ? M_OUT_A :
                       (ab == 2'b01) ? M_OUT_B : M_IDLE;
         M_OUT_A: begin
            if (ab == 2'b00) ext = 1'b1;
            s = (ab == 2'b10) ? M_OUT_A : (ab == 2'b11) ? M_OUT_AB : M_IDLE;
         end
         default:  s = M_IDLE;
      endcase
      mState[l] = s;
   endtask

   task automatic applyStimulus(input logic [LANES-1:0] aV, input logic [LANES-1:0] bV, input logic rstIn);
      expect_t e;
      expect_t got;
      int      n;
      logic    en, ex;
      @(negedge clk);
      rst          = rstIn;
      bus.sensor_a = aV;
      bus.sensor_b = bV;
      e.ent = '0;
      e.ext = '0;
      e.ovf = 1'b0;
      e.unf = 1'b0;
      if (rstIn) begin
         for (int l = 0; l < LANES; l++) mState[l] = M_IDLE;
         mCount = 0;
      end else begin
         n = mCount;
         for (int l = 0; l < LANES; l++) begin
            modelLane(l, {aV[l], bV[l]}, en, ex);
            e.ent[l] = en;
            e.ext[l] = ex;
            n = n + int'(en) - int'(ex);
         end
         if (n > CAPACITY) begin
            mCount = CAPACITY;
            e.ovf  = 1'b1;
         end else if (n < 0) begin
            mCount = 0;
            e.unf  = 1'b1;
         end else begin
            mCount = n;
         end
      end
      e.cnt = mCount;
      scoreboard.push_back(e);
      @(posedge clk);
      #1;
      cycleNo++;
      got = scoreboard.pop_front();
      checkOutput("pulses", 32'({bus.enter_pulse, bus.exit_pulse}), 32'({got.ent, got.ext}));
      checkOutput("count", 32'(bus.count), 32'(got.cnt));
      checkOutput("flags", 32'({bus.overflow, bus.underflow, bus.full, bus.empty}),
                  32'({got.ovf, got.unf, got.cnt == CAPACITY, got.cnt == 0}));
   endtask

   task automatic driveLane(input int lane, input logic [1:0] ab, input int cycles);
      logic [LANES-1:0] aV;
      logic [LANES-1:0] bV;
      aV = '0;
      bV = '0;
      aV[lane] = ab[1];
      bV[lane] = ab[0];
      for (int c = 0; c < cycles; c++) applyStimulus(aV, bV, 1'b0);
   endtask

   task automatic laneEntry(input int lane);
      driveLane(lane, 2'b10, 1);
      driveLane(lane, 2'b11, 1);
      driveLane(lane, 2'b01, 1);
      driveLane(lane, 2'b00, 1);
   endtask

   task automatic laneExit(input int lane);
      driveLane(lane, 2'b01, 1);
      driveLane(lane, 2'b11, 1);
      driveLane(lane, 2'b10, 1);
      driveLane(lane, 2'b00, 1);
   endtask

   task automatic allEntry();
      applyStimulus(4'hF, 4'h0, 1'b0);
      applyStimulus(4'hF, 4'hF, 1'b0);
      applyStimulus(4'h0, 4'hF, 1'b0);
      applyStimulus(4'h0, 4'h0, 1'b0);
   endtask

   initial begin
      total        = 0;
      bad          = 0;
      cycleNo      = 0;
      mCount       = 0;
      rst          = 1'b1;
      bus.sensor_a = '0;
      bus.sensor_b = '0;
      for (int l = 0; l < LANES; l++) mState[l] = M_IDLE;

      applyStimulus(4'h0, 4'h0, 1'b1);
      applyStimulus(4'h0, 4'h0, 1'b1);

      // Lane 0 complete entry, each pattern held two cycles.
      driveLane(0, 2'b10, 2);
      driveLane(0, 2'b11, 2);
      driveLane(0, 2'b01, 2);
      driveLane(0, 2'b00, 1);
      checkOutput("entry0Pulse", 32'(bus.enter_pulse), 32'h1);
      checkOutput("entry0Count", 32'(bus.count), 32'd1);
      driveLane(0, 2'b00, 1);
      checkOutput("entry0PulseEnd", 32'(bus.enter_pulse), 32'h0);

      // Lane 1 backs out, then completes an exit.
      driveLane(1, 2'b10, 2);
      driveLane(1, 2'b11, 2);
      driveLane(1, 2'b10, 2);
      driveLane(1, 2'b00, 2);
      checkOutput("backoutCount", 32'(bus.count), 32'd1);
      laneExit(1);
      checkOutput("exit1Count", 32'(bus.count), 32'd0);
      checkOutput("exit1Empty", 32'(bus.empty), 32'd1);

      // Exit on an empty lot clamps at zero.
      laneExit(1);
      checkOutput("underflowPulse", 32'({bus.underflow, bus.exit_pulse}), 32'h12);

      // Fill to 13, then all four lanes enter together.
      allEntry();
      allEntry();
      allEntry();
      laneEntry(0);
      checkOutput("count13", 32'(bus.count), 32'd13);
      allEntry();
      checkOutput("allEnterOvf", 32'({bus.overflow, bus.full, bus.enter_pulse}), 32'h3F);
      checkOutput("allEnterCount", 32'(bus.count), 32'd15);
      laneEntry(0);
      checkOutput("fullEntryOvf", 32'({bus.overflow, bus.count}), 32'h1F);

      // Entry on lane 0 and exit on lane 1 net out on a full lot.
      applyStimulus(4'b0001, 4'b0010, 1'b0);
      applyStimulus(4'b0011, 4'b0011, 1'b0);
      applyStimulus(4'b0010, 4'b0001, 1'b0);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      checkOutput("netOutCount", 32'({bus.overflow, bus.count}), 32'h0F);

      // Reset while lane 0 sits in the middle of an entry.
      driveLane(0, 2'b10, 1);
      driveLane(0, 2'b11, 1);
      applyStimulus(4'b0001, 4'b0001, 1'b1);
      checkOutput("midReset", 32'({bus.count, bus.empty}), 32'h01);
      driveLane(0, 2'b11, 2);
      driveLane(0, 2'b01, 2);
      driveLane(0, 2'b00, 2);
      checkOutput("postResetNoEvent", 32'(bus.count), 32'd0);

      // Random beam activity across all lanes.
      for (int k = 0; k < 400; k++) begin
         applyStimulus(LANES'($urandom_range(0, 15)), LANES'($urandom_range(0, 15)), 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/parking_lot_counter.md
# parking_lot_counter

Multi-lane parking-lot occupancy counter. Each lane has two beam sensors, `a` on the outside and `b` on the inside. A per-lane direction FSM recognises complete entry sequences (a → ab → b → clear) and complete exit sequences (b → ab → a → clear). Partial or backed-out passages are discarded. Events from all lanes are merged into one saturating occupancy count with full/empty status and overflow/underflow error pulses. The block sits between the sensor synchronisers and the lot-status display/gate-control logic.

## Interface
- `LANES`, default 2: number of independent lanes, ≥1.
- `CAPACITY`, default 15: maximum occupancy, ≥1.
- `CNT_W`, default `$clog2(CAPACITY+1)`: occupancy counter width.

- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-high.
- `sensor_a` in `LANES`: outer beam per lane, 1 = blocked; already synchronised.
- `sensor_b` in `LANES`: inner beam per lane, 1 = blocked; already synchronised.
- `enter_pulse` out `LANES`: one-cycle pulse per completed entry on that lane.
- `exit_pulse` out `LANES`: one-cycle pulse per completed exit on that lane.
- `count` out `CNT_W`: current occupancy, 0..`CAPACITY`.
- `full` out 1: `count == CAPACITY`.
- `empty` out 1: `count == 0`.
- `overflow` out 1: one-cycle pulse when an entry was clamped at `CAPACITY`.
- `underflow` out 1: one-cycle pulse when an exit was clamped at 0.

## Operation
- Each lane has its own FSM. Inputs are written as `{a,b}`. States: IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_AB, OUT_A.
- IDLE transitions:
  - 10 → IN_A
  - 01 → OUT_B
  - 00 and 11 → stay IDLE (11 is ambiguous and ignored until the beams clear)
- Entry path:
  - IN_A: 10 stay; 11 → IN_AB; 00 or 01 → IDLE (abort).
  - IN_AB: 11 stay; 01 → IN_B; 10 → IN_A (backing); 00 → IDLE (abort).
  - IN_B: 01 stay; 11 → IN_AB; 00 → IDLE and assert `enter_pulse`; 10 → IDLE (abort).
- Exit path (mirror of entry):
  - OUT_B: 01 stay; 11 → OUT_AB; 00 or 10 → IDLE (abort).
  - OUT_AB: 11 stay; 10 → OUT_A; 01 → OUT_B; 00 → IDLE (abort).
  - OUT_A: 10 stay; 11 → OUT_AB; 00 → IDLE and assert `exit_pulse`; 01 → IDLE (abort).
- Aborts never produce a pulse or change `count`.
- Count update per cycle:
  - `E` = popcount of lane entries completing this cycle; `X` = popcount of lane exits.
  - `next = count + E − X`, computed signed at width `CNT_W + $clog2(LANES+1) + 1`.
  - If `next > CAPACITY`: `count ← CAPACITY` and `overflow` pulses.
  - If `next < 0`: `count ← 0` and `underflow` pulses.
  - Otherwise `count ← next`.
- Simultaneous entry and exit on different lanes net out before saturation. Example: full lot with one entry and one exit → `count` unchanged, no `overflow`.
- `enter_pulse` and `exit_pulse` always reflect the physical event, even when the count clamps.
- `full` and `empty` are decoded combinationally from the `count` register.

## Timing
- The FSM samples its inputs at clock edge k.
- The transition completing a sequence registers `enter_pulse`/`exit_pulse` and the updated `count` at that same edge k. All are visible in cycle k..k+1.
- Latency from the beams clearing (00 sampled) to the pulse and count: 1 clock.
- `overflow`/`underflow` are registered at the same edge as the `count` update; each is high for exactly one cycle.
- Reset values:
  - all lane FSMs IDLE;
  - `count` = 0, `empty` = 1, `full` = 0;
  - all pulses and error flags 0.
- Reset mid-sequence discards the partial passage. After `rst` deasserts, a lane whose beams are still 11 stays IDLE until they clear.
- Lanes are fully independent; any combination of lanes may complete in the same cycle.
- Wrap-around never occurs: `count` is saturating only.

## Test plan
- Lane 0 drives 10, 11, 01, 00 (2 cycles each) from reset → `enter_pulse[0]` high for 1 cycle after 00 is sampled; `count` 0→1; `empty` falls the same cycle.
- Lane 1 drives 10, 11, 10, 00 (backs out) → no pulses, `count` unchanged. Then 01, 11, 10, 00 with `count` = 1 → `exit_pulse[1]`, `count` 1→0, `empty` = 1.
- With `count` = 0, a complete exit → `exit_pulse` high, `underflow` pulses, `count` stays 0.
- `CAPACITY` = 15 with `count` = 15: lane 0 completes an entry → `overflow` pulse, `count` = 15. Then lane 0 entry and lane 1 exit complete in the same cycle → `count` = 15, no `overflow`.
- `LANES` = 4, all four lanes complete entries in the same cycle at `count` = 13 → `count` = 15, `overflow` = 1, `full` = 1, all four `enter_pulse` bits high.
- Assert `rst` while lane 0 is in IN_AB (11) → all outputs at reset values next cycle. Hold 11 then 01, 00 → no event, `count` = 0.
